// File: rtl/photo_shutter_sequencer.sv
// Round-robin photoshutter sequencer: each qualified trigger edge fires the next
// enabled shutter for W ticks, then waits H ticks before re-arming.
module photo_shutter_sequencer #(
  parameter int unsigned PRESCALE       = 1000,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        TRIG,
  output logic        P1,
  output logic        P2,
  output logic        P3,
  output logic        TRIG_OUT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [PRESCALE_WIDTH-1:0] PRE_LAST = PRESCALE_WIDTH'(PRESCALE - 1);

  state_t                    state_q;
  logic                      sync1_q, sync2_q, sync3_q;
  logic [2:0]                mask_q;
  logic                      armed_q;
  logic [7:0]                w_q, h_q;
  logic [7:0]                wl_q, hl_q;
  logic [1:0]                ptr_q;
  logic [7:0]                cnt_q;
  logic [PRESCALE_WIDTH-1:0] pre_q;
  logic [7:0]                tcnt_q;
  logic [2:0]                p_q;
  logic                      trig_out_q;
  logic [31:0]               dat_o_q;

  logic                      rise, fire_go, abort, clr, tick, done, busy;
  logic [1:0]                sel_d;
  logic [7:0]                span;
  logic                      unused_dat;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    logic [1:0] r;
    r = (i == 2'd2) ? 2'd0 : i + 2'd1;
    return r;
  endfunction

  // First enabled shutter at or after the pointer, wrapping modulo 3.
  function automatic logic [1:0] pick_shutter(input logic [2:0] mask, input logic [1:0] ptr);
    logic [1:0] c0, c1, c2, r;
    c0 = ptr;
    c1 = inc3(c0);
    c2 = inc3(c1);
    if (mask[c0])      r = c0;
    else if (mask[c1]) r = c1;
    else               r = c2;
    return r;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] r;
    r = 3'b001 << idx;
    return r;
  endfunction

  assign rise       = sync2_q & ~sync3_q;
  assign fire_go    = rise & armed_q & (mask_q != 3'b000);
  assign abort      = wr_i & ~dat_i[3];
  assign clr        = wr_i & dat_i[4];
  assign sel_d      = pick_shutter(mask_q, ptr_q);
  assign tick       = (pre_q == PRE_LAST);
  assign span       = (state_q == HOLDOFF) ? hl_q : wl_q;
  assign done       = tick & (tcnt_q == span - 8'd1);
  assign busy       = (state_q != IDLE);
  assign unused_dat = ^{dat_i[31:24], dat_i[7:5]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      mask_q     <= 3'b000;
      armed_q    <= 1'b0;
      w_q        <= 8'd0;
      h_q        <= 8'd0;
      wl_q       <= 8'd0;
      hl_q       <= 8'd0;
      ptr_q      <= 2'd0;
      cnt_q      <= 8'd0;
      pre_q      <= '0;
      tcnt_q     <= 8'd0;
      p_q        <= 3'b000;
      trig_out_q <= 1'b0;
      dat_o_q    <= 32'd0;
    end else begin
      sync1_q    <= TRIG;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      trig_out_q <= 1'b0;

      if (wr_i) begin
        mask_q  <= dat_i[2:0];
        armed_q <= dat_i[3];
        w_q     <= dat_i[15:8];
        h_q     <= dat_i[23:16];
      end

      case (state_q)
        IDLE: begin
          pre_q  <= '0;
          tcnt_q <= 8'd0;
          if (fire_go) begin
            state_q    <= FIRE;
            wl_q       <= (w_q == 8'd0) ? 8'd1 : w_q;
            hl_q       <= h_q;
            p_q        <= onehot3(sel_d);
            trig_out_q <= 1'b1;
            cnt_q      <= cnt_q + 8'd1;
            ptr_q      <= inc3(sel_d);
          end
        end
        FIRE: begin
          if (abort) begin
            state_q <= IDLE;
            p_q     <= 3'b000;
          end else if (done) begin
            p_q    <= 3'b000;
            pre_q  <= '0;
            tcnt_q <= 8'd0;
            // Zero holdoff returns straight to IDLE.
            state_q <= (hl_q == 8'd0) ? IDLE : HOLDOFF;
          end else if (tick) begin
            pre_q  <= '0;
            tcnt_q <= tcnt_q + 8'd1;
          end else begin
            pre_q <= pre_q + PRESCALE_WIDTH'(1);
          end
        end
        HOLDOFF: begin
          if (abort || done) begin
            state_q <= IDLE;
          end else if (tick) begin
            pre_q  <= '0;
            tcnt_q <= tcnt_q + 8'd1;
          end else begin
            pre_q <= pre_q + PRESCALE_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          p_q     <= 3'b000;
        end
      endcase

      // Clear overrides the pointer/count update of a simultaneous fire.
      if (clr) begin
        ptr_q <= 2'd0;
        cnt_q <= 8'd0;
      end

      dat_o_q <= {cnt_q, h_q, w_q, 1'b0, ptr_q, busy, armed_q, mask_q};
    end
  end

  assign P1       = p_q[0];
  assign P2       = p_q[1];
  assign P3       = p_q[2];
  assign TRIG_OUT = trig_out_q;
  assign dat_o    = dat_o_q;

endmodule

// File: tb/tb_photo_shutter_sequencer.sv
// Directed bench for photo_shutter_sequencer with PRESCALE=4: vector table for
// round-robin firing plus hand sequences for holdoff, abort, clear, wrap and reset.
module tb_photo_shutter_sequencer;

  localparam int PS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        TRIG;
  logic        P1, P2, P3, TRIG_OUT;
  logic [2:0]  pvec;
  int          checks = 0;
  int          errors = 0;

  assign pvec = {P3, P2, P1};

  always #5 clk = ~clk;

  photo_shutter_sequencer #(.PRESCALE(PS), .PRESCALE_WIDTH(16)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .wr_i     (wr),
    .dat_i    (dat_i),
    .dat_o    (dat_o),
    .TRIG     (TRIG),
    .P1       (P1),
    .P2       (P2),
    .P3       (P3),
    .TRIG_OUT (TRIG_OUT)
  );

  typedef struct {
    logic        do_wr;
    logic [31:0] wdat;
    logic [2:0]  exp_p;
    int          exp_w;
    logic [7:0]  exp_cnt;
    logic [1:0]  exp_ptr;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [31:0] d);
    @(posedge clk); #1; wr = 1'b1; dat_i = d;
    @(posedge clk); #1; wr = 1'b0; dat_i = 32'd0;
  endtask

  task automatic pulse_trig();
    @(posedge clk); #1; TRIG = 1'b1;
    @(posedge clk); #1; TRIG = 1'b0;
  endtask

  // Latency is counted in clock edges from the edge that first sampled TRIG high.
  task automatic trig_and_measure(input int budget, output logic [2:0] who, output int lat,
                                  output int width, output int tocnt, output logic multi);
    who = 3'b000; lat = -1; width = 0; tocnt = 0; multi = 1'b0;
    pulse_trig();
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (TRIG_OUT) tocnt++;
      if ($countones(pvec) > 1) multi = 1'b1;
      if (lat < 0 && pvec != 3'b000) begin
        who = pvec;
        lat = k;
      end
      if (lat >= 0) begin
        if (pvec != 3'b000) width++;
        else break;
      end
    end
  endtask

  logic [2:0] who;
  int         lat, width, tocnt;
  logic       multi, seen;
  logic [2:0] cfg_mask;
  logic       cfg_arm;
  logic [7:0] cfg_w, cfg_h;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_020F, 3'b001, 8,  8'd1, 2'd1};
    vecs[1]  = '{1'b0, 32'h0000_0000, 3'b010, 8,  8'd2, 2'd2};
    vecs[2]  = '{1'b0, 32'h0000_0000, 3'b100, 8,  8'd3, 2'd0};
    vecs[3]  = '{1'b1, 32'h0000_010D, 3'b001, 4,  8'd4, 2'd1};
    vecs[4]  = '{1'b0, 32'h0000_0000, 3'b100, 4,  8'd5, 2'd0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 3'b001, 4,  8'd6, 2'd1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 3'b100, 4,  8'd7, 2'd0};
    vecs[7]  = '{1'b1, 32'h0000_0108, 3'b000, 0,  8'd7, 2'd0};
    vecs[8]  = '{1'b1, 32'h0000_0107, 3'b000, 0,  8'd7, 2'd0};
    vecs[9]  = '{1'b1, 32'h0000_000A, 3'b010, 4,  8'd8, 2'd2};
    vecs[10] = '{1'b1, 32'h0000_030E, 3'b100, 12, 8'd9, 2'd0};
    vecs[11] = '{1'b1, 32'h0000_011F, 3'b001, 4,  8'd1, 2'd1};

    rst_n = 1'b0; wr = 1'b0; dat_i = 32'd0; TRIG = 1'b0;
    cfg_mask = 3'b000; cfg_arm = 1'b0; cfg_w = 8'd0; cfg_h = 8'd0;
    #1;
    check("reset_p", 32'(pvec), 32'd0);
    check("reset_trig_out", 32'(TRIG_OUT), 32'd0);
    check("reset_dat_o", dat_o, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_dat_o", dat_o, 32'd0);

    // ---- table-driven round-robin vectors ----
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) begin
        write_reg(vecs[i].wdat);
        cfg_mask = vecs[i].wdat[2:0];
        cfg_arm  = vecs[i].wdat[3];
        cfg_w    = vecs[i].wdat[15:8];
        cfg_h    = vecs[i].wdat[23:16];
      end
      trig_and_measure((vecs[i].exp_p == 3'b000) ? 20 : 60, who, lat, width, tocnt, multi);
      check($sformatf("v%0d_shutter", i), 32'(who), 32'(vecs[i].exp_p));
      check($sformatf("v%0d_onehot", i), 32'(multi), 32'd0);
      check($sformatf("v%0d_trig_out_count", i), 32'(tocnt), (vecs[i].exp_p != 3'b000) ? 32'd1 : 32'd0);
      if (vecs[i].exp_p != 3'b000) begin
        check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
        check($sformatf("v%0d_width", i), 32'(width), 32'(vecs[i].exp_w));
      end
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_dat_o", i), dat_o,
            {vecs[i].exp_cnt, cfg_h, cfg_w, 1'b0, vecs[i].exp_ptr, 1'b0, cfg_arm, cfg_mask});
    end

    // ---- holdoff: retrigger inside holdoff is dropped, later one fires ----
    write_reg(32'h0003_010F);
    trig_and_measure(60, who, lat, width, tocnt, multi);
    check("ho_first_shutter", 32'(who), 32'b010);
    check("ho_first_width", 32'(width), 32'd4);
    repeat (3) @(posedge clk);
    #1 TRIG = 1'b1;
    @(posedge clk); #1 TRIG = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (pvec != 3'b000 || TRIG_OUT) seen = 1'b1;
    end
    check("ho_ignored_fire", 32'(seen), 32'd0);
    check("ho_busy", 32'(dat_o[4]), 32'd1);
    check("ho_count_held", 32'(dat_o[31:24]), 32'd2);
    repeat (6) @(posedge clk);
    trig_and_measure(60, who, lat, width, tocnt, multi);
    check("ho_late_shutter", 32'(who), 32'b100);
    check("ho_late_latency", 32'(lat), 32'd2);
    check("ho_late_width", 32'(width), 32'd4);
    repeat (14) @(posedge clk);

    // ---- abort mid-FIRE by writing arm=0 ----
    write_reg(32'h0000_040F);
    pulse_trig();
    repeat (2) @(posedge clk);
    #1;
    check("abort_pre_p", 32'(pvec), 32'b001);
    write_reg(32'h0000_0407);
    check("abort_p_low", 32'(pvec), 32'd0);
    @(posedge clk); #1;
    check("abort_busy", 32'(dat_o[4]), 32'd0);
    check("abort_count", 32'(dat_o[31:24]), 32'd4);

    // ---- clear coincident with FIRE entry ----
    write_reg(32'h0000_010F);
    pulse_trig();
    @(posedge clk); #1; wr = 1'b1; dat_i = 32'h0000_011F;
    @(posedge clk); #1; wr = 1'b0; dat_i = 32'd0;
    check("clr_fire_p", 32'(pvec), 32'b010);
    check("clr_fire_trig_out", 32'(TRIG_OUT), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("clr_count", 32'(dat_o[31:24]), 32'd0);
    check("clr_ptr", 32'(dat_o[6:5]), 32'd0);

    // ---- fire count wraps 255 -> 0 ----
    for (int n = 0; n < 255; n++) begin
      pulse_trig();
      repeat (7) @(posedge clk);
    end
    #1;
    check("wrap_count_255", 32'(dat_o[31:24]), 32'd255);
    pulse_trig();
    repeat (7) @(posedge clk);
    #1;
    check("wrap_count_0", 32'(dat_o[31:24]), 32'd0);

    // ---- asynchronous reset mid-FIRE, TRIG held high through release ----
    write_reg(32'h0000_040F);
    pulse_trig();
    repeat (4) @(posedge clk);
    #3;
    check("rst_pre_active", 32'(pvec != 3'b000), 32'd1);
    rst_n = 1'b0;
    TRIG  = 1'b1;
    #1;
    check("rst_async_p", 32'(pvec), 32'd0);
    check("rst_async_trig_out", 32'(TRIG_OUT), 32'd0);
    check("rst_async_dat_o", dat_o, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    write_reg(32'h0000_010F);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (pvec != 3'b000 || TRIG_OUT) seen = 1'b1;
    end
    check("rst_held_trig_ignored", 32'(seen), 32'd0);
    check("rst_dat_o_cfg", dat_o, 32'h0000_010F);
    TRIG = 1'b0;
    repeat (3) @(posedge clk);
    trig_and_measure(60, who, lat, width, tocnt, multi);
    check("rst_new_edge_shutter", 32'(who), 32'b001);
    check("rst_new_edge_latency", 32'(lat), 32'd2);
    check("rst_new_edge_width", 32'(width), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/photo_shutter_sequencer.md
Name: photo_shutter_sequencer

Overview:
Controls the three photoshutter drive lines P1/P2/P3 from the external photo trigger. Each qualified trigger rising edge fires the next enabled shutter in round-robin order. The pulse has a programmable width, and a programmable holdoff follows it. Sits between the board trigger input and the shutter drivers, replacing direct pingpong drive, and is configured and read back over the standard 32-bit register strobe interface.

Parameters:
PRESCALE, 1000, clk_i cycles per timing tick; legal range 1..65535.
PRESCALE_WIDTH, 16, width of the prescale counter; must satisfy PRESCALE <= 2^PRESCALE_WIDTH.

Ports:
clk_i  input  1  system clock; all logic is on the rising edge.
rst_n_i  input  1  asynchronous active-low reset.
wr_i  input  1  register write strobe; one cycle, dat_i valid.
dat_i  input  32  write data: [2:0] shutter enable mask (bit0=P1), [3] arm, [4] clear (self-clearing), [15:8] width W in ticks, [23:16] holdoff H in ticks; other bits ignored.
dat_o  output  32  status: [2:0] mask, [3] armed, [4] busy (state != IDLE), [6:5] next shutter index 0..2, [7] 0, [15:8] W, [23:16] H, [31:24] fire count.
TRIG  input  1  asynchronous trigger from the board.
P1  output  1  shutter 1 drive, active high, registered.
P2  output  1  shutter 2 drive, active high, registered.
P3  output  1  shutter 3 drive, active high, registered.
TRIG_OUT  output  1  one-cycle pulse marking each shutter fire, registered.

Behaviour:
- Reset (async assert, release synchronous to clk_i): P1..P3=0, TRIG_OUT=0, mask=0, armed=0, W=0, H=0, pointer=0, fire count=0, state=IDLE, dat_o=0, sync flops=0.
- TRIG passes through a 2-FF synchronizer plus an edge register. rise = sync2 & ~sync3.
- States are IDLE, FIRE and HOLDOFF.
- IDLE -> FIRE on rise when armed=1 and mask!=0. Otherwise rise is dropped.
- At FIRE entry:
  - Select the first enabled shutter at index pointer, pointer+1, pointer+2 (mod 3), and latch its index.
  - Latch W and H; W=0 is treated as 1.
  - Assert that shutter's P.
  - Pulse TRIG_OUT for 1 cycle.
  - Increment fire count (8-bit, wraps 255->0).
  - Set pointer = selected index+1 mod 3.
  - Reset the prescaler to 0.
- Latency: TRIG first sampled high at edge N -> P and TRIG_OUT high after edge N+2.
- Only one P is high at any time.
- FIRE lasts exactly Wlatched*PRESCALE cycles. The prescaler restarts at FIRE and HOLDOFF entry, so tick phase is deterministic.
- FIRE exit: P deasserts. If Hlatched=0, go to IDLE; else go to HOLDOFF for Hlatched*PRESCALE cycles, then IDLE.
- Minimum retrigger spacing: a rise in the same cycle IDLE is re-entered is ignored; the next rise fires.
- rise during FIRE or HOLDOFF is ignored and not queued.
- Register writes:
  - wr_i updates mask, armed, W and H on the next edge.
  - A write during FIRE/HOLDOFF does not alter the latched W/H or the selected shutter.
  - Exception: a write with arm=0 during FIRE or HOLDOFF aborts. P goes low and state goes to IDLE on the next edge.
- Clear (dat_i[4]=1 with wr_i): pointer=0 and fire count=0 on the next edge; not stored.
  - Clear in the same cycle as FIRE entry: clear wins (count=0, pointer=0), but the fire itself still proceeds.
  - Clear during FIRE does not abort the pulse.
- A write that sets mask=0 while armed does not abort an in-progress fire.
- dat_o is registered and reflects state one cycle after any change.

Test Plan:
- PRESCALE=4: write mask=7, arm=1, W=2, H=0; pulse TRIG 3 times -> P1, P2, P3 each high exactly 8 cycles, rising 2 edges after TRIG sampled; TRIG_OUT 1-cycle each; dat_o[31:24]=3, dat_o[6:5]=0.
- mask=5 (P1,P3), 4 triggers -> order P1,P3,P1,P3; P2 never asserts.
- W=1, H=3, PRESCALE=4: second TRIG 5 cycles after P falls -> ignored (busy=1, count unchanged); TRIG after 12+ cycles -> fires.
- armed=0 or mask=0: TRIG -> no P, no TRIG_OUT, count unchanged. Write arm=0 mid-FIRE -> P low after the next edge, busy=0.
- Clear written on the FIRE-entry cycle -> the pulse still occurs, then dat_o[31:24]=0 and pointer=0. Fire count from 255 with one more fire -> 0.
- Assert rst_n_i low mid-FIRE -> P1..P3, TRIG_OUT and dat_o go to 0 immediately (asynchronously). After release, TRIG held high stays ignored until a new rising edge.
